// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver. Synchronizes the serial line,
// finds the start edge, takes a 2-of-3 majority vote around each bit centre and
// delivers each DATA_WIDTH-bit word with parity/framing status and a valid strobe.
module uart_rx_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  clk_enable,
    input  logic                  parity_en,
    input  logic                  rx_uart,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_data_valid,
    output logic                  rx_data_error,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det
);

    localparam int   IDX_W = $clog2(DATA_WIDTH);
    localparam logic ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxs;
    logic [3:0]              cnt;
    logic                    s7;
    logic                    s8;
    logic                    maj;
    logic                    mid_tick;
    logic                    end_tick;
    logic                    last_bit;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_q;
    logic                    par_err_q;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign maj       = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    assign mid_tick  = clk_enable && (cnt == 4'd9);
    assign end_tick  = clk_enable && (cnt == 4'd15);
    assign last_bit  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign break_det = (state_q == ST_BREAK);

    // Bring the asynchronous serial line into the clk domain; idle level is 1.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_uart};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decisions; every transition is taken on a baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (clk_enable && !rxs) state_d = ST_START;
            ST_START: begin
                if (mid_tick && maj)   state_d = ST_IDLE;
                else if (end_tick)     state_d = ST_DATA;
            end
            ST_DATA:   if (end_tick && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (end_tick) state_d = ST_STOP;
            // Decide at the stop-bit centre so the next start edge can resync early.
            ST_STOP:   if (mid_tick) state_d = (!maj && (shreg == '0)) ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (clk_enable && rxs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Tick counter, majority samples, data shift register and parity check.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt       <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
        end else if (clk_enable) begin
            if (cnt == 4'd7) s7 <= rxs;
            if (cnt == 4'd8) s8 <= rxs;
            case (state_q)
                ST_IDLE: begin
                    // The detection tick counts as cnt = 0 of the start bit.
                    cnt <= rxs ? 4'd0 : 4'd1;
                    if (!rxs) begin
                        par_en_q <= parity_en;
                        bit_idx  <= '0;
                    end
                end
                ST_BREAK: cnt <= 4'd0;
                ST_DATA: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9)  shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                    if (cnt == 4'd15) bit_idx <= bit_idx + IDX_W'(1);
                end
                ST_PARITY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) par_err_q <= (((^shreg) ^ maj) != ODD);
                end
                default: cnt <= cnt + 4'd1;
            endcase
        end
    end

    // Output word and status, loaded together at the stop-bit decision.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            rx_data_error <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            if ((state_q == ST_STOP) && mid_tick) begin
                rx_data       <= shreg;
                rx_data_valid <= 1'b1;
                parity_err    <= par_en_q & par_err_q;
                frame_err     <= ~maj;
                rx_data_error <= ~maj | (par_en_q & par_err_q);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: drives serial frames tick by tick and checks every clk
// cycle against a frame-level model (expected strobe tick, word and status).
module tb_uart_rx_engine;

    localparam int DW   = 8;
    localparam int PODD = 0;

    logic          clk;
    logic          areset_n;
    logic          clk_enable;
    logic          parity_en;
    logic          rx_uart;
    logic [DW-1:0] rx_data;
    logic          rx_data_valid;
    logic          rx_data_error;
    logic          parity_err;
    logic          frame_err;
    logic          break_det;

    uart_rx_engine #(.DATA_WIDTH(DW), .PARITY_ODD(PODD), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .areset_n(areset_n),
        .clk_enable(clk_enable),
        .parity_en(parity_en),
        .rx_uart(rx_uart),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_error(rx_data_error),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .break_det(break_det)
    );

    typedef struct {
        int            tick;
        logic [DW-1:0] data;
        bit            perr;
        bit            ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   tick_no = 0;
    int   tick_pre = 2;
    int   tick_post = 0;
    bit   gap_en = 0;
    int   strobe_cnt = 0;
    int   last_strobe_tick = -1;
    int   last_t0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One baud tick: line settles, then a one-cycle clk_enable pulse.
    task automatic do_tick(input logic line);
        rx_uart = line;
        repeat (tick_pre) @(negedge clk);
        clk_enable = 1'b1;
        @(negedge clk);
        clk_enable = 1'b0;
        tick_no++;
        repeat (tick_post) @(negedge clk);
        if (gap_en && ($urandom_range(0, 7) == 0)) repeat (20) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) do_tick(1'b1);
    endtask

    // Sends one frame and records what the receiver must report and when.
    task automatic send_frame(input logic [DW-1:0] data, input bit pen, input bit pbit,
                              input bit stop_val, input int stop_ticks, input int glitch,
                              input bit toggle);
        int   nb;
        int   tot;
        exp_t e;
        nb        = 1 + DW + (pen ? 1 : 0);
        parity_en = pen;
        last_t0   = tick_no;
        e.tick    = tick_no + 16 * nb + 9;
        e.data    = data;
        e.perr    = pen && (((^data) ^ pbit) != PODD);
        e.ferr    = !stop_val;
        exp_q.push_back(e);
        tot = 16 * nb + stop_ticks;
        for (int t = 0; t < tot; t++) begin
            int   b;
            logic v;
            b = t / 16;
            if (b == 0)                    v = 1'b0;
            else if (b <= DW)              v = data[b-1];
            else if (pen && (b == DW + 1)) v = pbit;
            else                           v = stop_val;
            if (t == glitch) v = ~v;
            if (toggle && (t == 40)) parity_en = ~parity_en;
            do_tick(v);
        end
    endtask

    // Per-cycle comparison against the frame model.
    initial begin : compare
        bit en_s;
        bit rst_s;
        int tn_s;
        bit exp_v;
        forever begin
            @(posedge clk);
            en_s  = clk_enable;
            rst_s = areset_n;
            tn_s  = tick_no;
            #1;
            exp_v = en_s && rst_s && (exp_q.size() > 0) && (exp_q[0].tick == tn_s);
            chk("valid", rx_data_valid, exp_v);
            if (rx_data_valid === 1'b1) begin
                strobe_cnt++;
                last_strobe_tick = tn_s;
            end
            if (exp_v) begin
                chk("rx_data", rx_data, exp_q[0].data);
                chk("parity_err", parity_err, exp_q[0].perr);
                chk("frame_err", frame_err, exp_q[0].ferr);
                chk("rx_data_error", rx_data_error, exp_q[0].perr | exp_q[0].ferr);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        int n0;
        areset_n   = 1'b0;
        clk_enable = 1'b0;
        parity_en  = 1'b0;
        rx_uart    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_data_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_err", rx_data_error, 0);
        chk("rst_break", break_det, 0);
        areset_n = 1'b1;
        idle(20);

        // Basic word and latency.
        send_frame(8'hA5, 0, 0, 1, 16, -1, 0);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_err", rx_data_error, 0);
        chk("a5_latency", last_strobe_tick - last_t0, 153);
        idle(10);

        // Reset in the middle of a frame.
        parity_en = 1'b0;
        for (int t = 0; t < 70; t++) do_tick((t < 16) ? 1'b0 : 1'b1);
        #2 areset_n = 1'b0;
        #1;
        chk("midrst_data", rx_data, 0);
        chk("midrst_break", break_det, 0);
        rx_uart = 1'b1;
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        chk("midrst_valid", rx_data_valid, 0);
        chk("midrst_ferr", frame_err, 0);
        idle(20);
        send_frame(8'h5A, 0, 0, 1, 16, -1, 0);
        chk("5a_data", rx_data, 8'h5A);
        idle(5);

        // Parity.
        send_frame(8'h07, 1, 1, 1, 16, -1, 0);
        chk("par_ok", parity_err, 0);
        send_frame(8'h07, 1, 0, 1, 16, -1, 0);
        chk("par_bad", parity_err, 1);
        chk("par_bad_err", rx_data_error, 1);
        send_frame(8'h07, 1, 0, 1, 16, -1, 1);
        chk("par_toggle_bad", parity_err, 1);
        send_frame(8'h07, 0, 0, 1, 16, -1, 1);
        chk("par_toggle_off", parity_err, 0);
        chk("par_toggle_latency", last_strobe_tick - last_t0, 153);
        idle(5);

        // False start and an out-voted mid-bit glitch.
        n0 = strobe_cnt;
        do_tick(1'b0); do_tick(1'b0); do_tick(1'b0);
        idle(40);
        chk("false_start", strobe_cnt - n0, 0);
        send_frame(8'h3C, 0, 0, 1, 16, 16 * 3 + 8, 0);
        chk("glitch_data", rx_data, 8'h3C);
        idle(5);

        // Framing error then break.
        send_frame(8'h81, 0, 0, 0, 16, -1, 0);
        idle(30);
        chk("ferr_81", frame_err, 1);
        chk("ferr_81_data", rx_data, 8'h81);
        chk("ferr_81_break", break_det, 0);
        n0 = strobe_cnt;
        parity_en = 1'b0;
        exp_q.push_back('{tick_no + 153, 8'h00, 1'b0, 1'b1});
        repeat (320) do_tick(1'b0);
        chk("brk_strobes", strobe_cnt - n0, 1);
        chk("brk_det_hi", break_det, 1);
        chk("brk_data", rx_data, 8'h00);
        chk("brk_ferr", frame_err, 1);
        do_tick(1'b1);
        chk("brk_det_lo", break_det, 0);
        idle(20);
        send_frame(8'h55, 0, 0, 1, 16, -1, 0);
        chk("55_data", rx_data, 8'h55);

        // Random frames with random parity, stop length and clock-enable gaps.
        gap_en = 1;
        for (int i = 0; i < 6; i++) begin
            send_frame(DW'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       1, $urandom_range(10, 24), -1, bit'($urandom_range(0, 1)));
        end
        gap_en = 0;
        idle(5);

        // Throughput: back-to-back frames on a 16-cycle tick.
        tick_pre  = 7;
        tick_post = 8;
        n0 = strobe_cnt;
        for (int i = 0; i < 32; i++) send_frame(DW'($urandom), 0, 0, 1, 16, -1, 0);
        idle(4);
        chk("thru_strobes", strobe_cnt - n0, 32);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

16x-oversampling UART receive engine that converts the serial `rx_uart` line into byte-wide words with per-word error status. It consumes the single-cycle 16x baud tick produced by the baud-rate divider and pushes results into the rx AXI-Stream FIFO: `rx_data` goes to the FIFO `tdata`, `rx_data_valid` to `tvalid`, and `!rx_data_error` to `tkeep`. Frame format is 1 start bit, DATA_WIDTH data bits sent LSB-first, an optional parity bit, and 1 stop bit.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity
- SYNC_STAGES, 2, flops in the `rx_uart` synchronizer (>=2)

Ports:
- clk  input  1  system clock; the only clock
- areset_n  input  1  asynchronous, active-low reset
- clk_enable  input  1  16x baud tick, one `clk` wide
- parity_en  input  1  1 = a parity bit follows the data bits
- rx_uart  input  1  serial line; asynchronous to `clk`; idle level 1
- rx_data  output  DATA_WIDTH  last received word
- rx_data_valid  output  1  one-cycle strobe marking a completed frame
- rx_data_error  output  1  parity_err OR frame_err; qualified by valid
- parity_err  output  1  parity mismatch; qualified by valid
- frame_err  output  1  stop bit sampled as 0; qualified by valid
- break_det  output  1  high while in BREAK state

## Operation
- Synchronizer: `rx_uart` passes through SYNC_STAGES flops, all reset to 1. The synchronized line is called `rxs`.
- Tick counter `cnt` (4 bits) advances only on `clk_enable`. It wraps 15->0. Each bit period is 16 ticks.
- Mid-bit sampling: `rxs` is sampled on the ticks where cnt = 7, 8 and 9. The bit value is the 2-of-3 majority, decided on the cnt = 9 tick.
- States:
  - IDLE: on a tick with rxs = 0, go to START with cnt = 0. Latch `parity_en` into `par_en_q` at this point.
  - START: at cnt = 9, if the majority is 1 this is a false start; return to IDLE with no output. At cnt = 15, go to DATA.
  - DATA: shift the majority bit in LSB-first at cnt = 9. Bit index runs 0..DATA_WIDTH-1. After the last bit's cnt = 15, go to PARITY if `par_en_q` is 1, else to STOP.
  - PARITY: at cnt = 9, compute parity_err = (XOR of data bits XOR majority) != PARITY_ODD. At cnt = 15, go to STOP.
  - STOP: at cnt = 9, frame_err = !majority. Then:
    - if frame_err and the data word is all zeros, go to BREAK;
    - otherwise go to IDLE.
    - Do not wait for the remaining stop ticks. This allows resync on the next start edge.
  - BREAK: `break_det` = 1. Leave to IDLE on the first tick with rxs = 1.
- Output update happens only on the STOP cnt = 9 tick:
  - `rx_data` is registered from the shift register and held until the next frame completes;
  - `parity_err`, `frame_err` and `rx_data_error` are registered with it (parity_err = 0 when `par_en_q` = 0);
  - `rx_data_valid` = 1 for exactly one `clk` cycle.
- A break frame still produces a valid strobe with frame_err = 1 and rx_data = 0.
- `parity_en` changes mid-frame have no effect on the current frame.
- There is no backpressure. The downstream FIFO must accept the word in the valid cycle, or the word is lost.

## Timing
- Reset (areset_n = 0, asynchronous): state = IDLE, cnt = 0, synchronizer flops = 1, rx_data = 0, rx_data_valid = 0, parity_err = 0, frame_err = 0, rx_data_error = 0, break_det = 0.
- Deassertion of areset_n must be synchronized externally to `clk`.
- Reset asserted mid-frame: the partial frame is discarded and no valid strobe is produced.
- Input latency: the line reaches `rxs` after SYNC_STAGES `clk` cycles.
- Detection tick to valid strobe = 16·(1 + DATA_WIDTH + par_en_q) + 9 ticks, plus 1 `clk`. The detection tick is the one on which IDLE sees rxs = 0.
- Example, DATA_WIDTH = 8, no parity: 153 ticks.
- With no `clk_enable` pulses, all state is frozen; outputs hold their values and valid stays 0.
- Start-edge error: up to 1 tick plus SYNC_STAGES clk. Sampling stays within ±1/16 bit of centre.
- Back-to-back frames: a start edge arriving 7 ticks after the STOP decision is accepted.

## Test plan
- Reset check: drive areset_n = 0 mid-frame, then release. Required: all outputs equal their reset values, and the next clean frame 0x5A is received correctly.
- Basic receive, DATA_WIDTH = 8, no parity, 0xA5 sent LSB-first: exactly one valid strobe, rx_data = 0xA5, error outputs 0, at 153 ticks plus 1 clk.
- Parity: even parity, byte 0x07 with parity bit 1 -> parity_err = 0. Same byte with parity bit 0 -> parity_err = 1 and rx_data_error = 1. Toggling parity_en mid-frame does not change the result.
- Glitch rejection: a 3-tick low pulse on an idle line -> false start, no valid. A single-tick glitch inside a data bit at cnt = 8 is out-voted by majority, and 0x3C is still received intact.
- Framing and break: stop bit 0 with data 0x81 -> frame_err = 1, next state IDLE. Line held low for 2 frame times -> one valid with rx_data = 0x00 and frame_err = 1, break_det stays high until the line returns to 1, then frame 0x55 is received.
- Throughput: 32 back-to-back random frames at minimum stop length with a 16-cycle clk_enable period -> 32 valid strobes with data matching the sent sequence.
